// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables, store replication, load extension
// and legality/alignment decode for one RV32I memory access.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_lane;

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be         = '0;
    o_wdata      = '0;
    o_rdata      = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      LSU_B: begin
        o_be    = i_write ? (4'b0001 << i_addr_lo) : 4'b1111;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      LSU_H: begin
        o_misaligned = i_addr_lo[0];
        o_be         = i_write ? (4'b0011 << i_addr_lo) : 4'b1111;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      LSU_W: begin
        o_misaligned = |i_addr_lo;
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = w_lane;
      end
      LSU_BU: begin
        // Unsigned variants exist only for loads.
        o_illegal = i_write;
        o_be      = 4'b1111;
        o_rdata   = {24'd0, w_lane[7:0]};
      end
      LSU_HU: begin
        o_illegal    = i_write;
        o_misaligned = i_addr_lo[0];
        o_be         = 4'b1111;
        o_rdata      = {16'd0, w_lane[15:0]};
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request/acknowledge data-memory transaction per
// core request, with registered bus outputs, timeout and fault reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              LSU_Req,
  input  logic              LSU_Write,
  input  logic [2:0]        LSU_Funct3,
  input  logic [AWIDTH-1:0] LSU_Addr,
  input  logic [DWIDTH-1:0] LSU_Wdata,
  output logic [DWIDTH-1:0] LSU_Rdata,
  output logic              LSU_Done,
  output logic              LSU_Fault,
  output logic              LSU_Busy,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [AWIDTH-1:0] Mem_Addr,
  output logic [DWIDTH-1:0] Mem_Wdata,
  output logic [3:0]        Mem_Be,
  input  logic              Mem_Ack,
  input  logic [DWIDTH-1:0] Mem_Rdata
);

  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t        r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_write;
  logic              r_mem_req, r_mem_we;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_fault;

  logic        w_idle, w_write, w_bad, w_tout;
  logic [2:0]  w_funct3;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata;
  logic        w_misaligned, w_illegal;

  // Decode live inputs while idle; the registered copy drives load extension in WAIT.
  assign w_idle    = (r_state == IDLE);
  assign w_funct3  = w_idle ? LSU_Funct3 : r_funct3;
  assign w_addr_lo = w_idle ? LSU_Addr[1:0] : r_addr_lo;
  assign w_write   = w_idle ? LSU_Write : r_write;
  assign w_bad     = w_misaligned | w_illegal;
  assign w_tout    = !Mem_Ack && (r_cnt == CNT_LAST);

  lsu_data_align u_align (
    .i_write      (w_write),
    .i_funct3     (w_funct3),
    .i_addr_lo    (w_addr_lo),
    .i_wdata      (LSU_Wdata),
    .i_rdata      (Mem_Rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (LSU_Req) w_next = w_bad ? DONE : WAIT;
      WAIT:    if (Mem_Ack || w_tout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    LSU_Done = (r_state == DONE);
    LSU_Busy = (r_state != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_cnt       <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_write     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (LSU_Req) begin
            if (w_bad) begin
              r_fault <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_funct3    <= LSU_Funct3;
              r_addr_lo   <= LSU_Addr[1:0];
              r_write     <= LSU_Write;
              r_mem_req   <= 1'b1;
              r_mem_we    <= LSU_Write;
              r_mem_addr  <= {LSU_Addr[AWIDTH-1:2], 2'b00};
              r_mem_wdata <= LSU_Write ? w_wdata : '0;
              r_mem_be    <= w_be;
            end
          end
        end
        WAIT: begin
          if (Mem_Ack || w_tout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_rdata     <= (Mem_Ack && !r_write) ? w_rdata : '0;
            r_fault     <= !Mem_Ack;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_fault <= 1'b0;
          r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign LSU_Rdata = r_rdata;
  assign LSU_Fault = r_fault;
  assign Mem_Req   = r_mem_req;
  assign Mem_We    = r_mem_we;
  assign Mem_Addr  = r_mem_addr;
  assign Mem_Wdata = r_mem_wdata;
  assign Mem_Be    = r_mem_be;

endmodule
